// File: rtl/data_ram_responder.sv
// Data-cache RAM responder: single-port word array behind one serial FSM, round-robin read/write arbitration.
// Latency: Done pulses READ_LAT/WRITE_LAT cycles after the accepting cycle; one transaction per LAT+1 cycles.
// Backpressure: requests are level-held and ignored until IDLE; DATA_RAM_PERF_EN adds activity counters.
module data_ram_responder #(
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 4
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        RamRead,
    input  logic [31:0] RamReadAddress,
    input  logic        RamWrite,
    input  logic [31:0] RamWriteAddress,
    input  logic [31:0] RamWriteData,
    output logic [31:0] RamData,
    output logic        DoneReadingData,
    output logic        DoneWritingData,
    output logic        Busy
`ifdef DATA_RAM_PERF_EN
    ,
    output logic [31:0] RdCount,
    output logic [31:0] WrCount,
    output logic [31:0] ConflictCount
`endif
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_BUSY = 3'd1,
        WR_BUSY = 3'd2,
        RD_DONE = 3'd3,
        WR_DONE = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  idx;
    logic               last_grant_wr;
    logic [31:0]        mem [0:(1 << ADDR_W) - 1];

    logic [ADDR_W-1:0]  rd_idx_in;
    logic [ADDR_W-1:0]  wr_idx_in;
    logic               both_req;
    logic               contend;
    logic               grant_rd;
    logic               grant_wr;

    // Address bits outside the word index are deliberately discarded (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{RamReadAddress[31:ADDR_W+2], RamReadAddress[1:0],
                                RamWriteAddress[31:ADDR_W+2], RamWriteAddress[1:0]};

    assign rd_idx_in = RamReadAddress[ADDR_W+1:2];
    assign wr_idx_in = RamWriteAddress[ADDR_W+1:2];
    assign both_req  = (state == IDLE) && RamRead && RamWrite;

    // Same-word contention always favours the write so the read observes the new data.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        contend  = 1'b0;
        if (state == IDLE) begin
            if (both_req) begin
                if (rd_idx_in == wr_idx_in) begin
                    grant_wr = 1'b1;
                end else begin
                    contend  = 1'b1;
                    grant_rd = last_grant_wr;
                    grant_wr = !last_grant_wr;
                end
            end else begin
                grant_rd = RamRead;
                grant_wr = RamWrite;
            end
        end
    end

    // The array has no reset: contents, including a committed write, survive nReset.
    always_ff @(posedge clk) begin
        if (grant_wr) begin
            mem[wr_idx_in] <= RamWriteData;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state           <= IDLE;
            cnt             <= '0;
            idx             <= '0;
            last_grant_wr   <= 1'b1;
            RamData         <= '0;
            DoneReadingData <= 1'b0;
            DoneWritingData <= 1'b0;
            Busy            <= 1'b0;
        end else begin
            DoneReadingData <= 1'b0;
            DoneWritingData <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        idx  <= wr_idx_in;
                        Busy <= 1'b1;
                        if (contend) last_grant_wr <= 1'b1;
                        if (WRITE_LAT == 1) begin
                            state           <= WR_DONE;
                            cnt             <= '0;
                            DoneWritingData <= 1'b1;
                        end else begin
                            state <= WR_BUSY;
                            cnt   <= WR_LOAD;
                        end
                    end else if (grant_rd) begin
                        idx  <= rd_idx_in;
                        Busy <= 1'b1;
                        if (contend) last_grant_wr <= 1'b0;
                        if (READ_LAT == 1) begin
                            state           <= RD_DONE;
                            cnt             <= '0;
                            DoneReadingData <= 1'b1;
                            RamData         <= mem[rd_idx_in];
                        end else begin
                            state <= RD_BUSY;
                            cnt   <= RD_LOAD;
                        end
                    end
                end
                RD_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state           <= RD_DONE;
                        DoneReadingData <= 1'b1;
                        RamData         <= mem[idx];
                    end
                end
                WR_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state           <= WR_DONE;
                        DoneWritingData <= 1'b1;
                    end
                end
                RD_DONE, WR_DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DATA_RAM_PERF_EN
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            RdCount       <= '0;
            WrCount       <= '0;
            ConflictCount <= '0;
        end else begin
            if (grant_rd) RdCount       <= RdCount + 32'd1;
            if (grant_wr) WrCount       <= WrCount + 32'd1;
            if (both_req) ConflictCount <= ConflictCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: two instances (LAT 4/4 and 1/1), transaction-level model checked every cycle.
module tb_data_ram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [2];
    logic        rd_req  [2];
    logic [31:0] rd_addr [2];
    logic        wr_req  [2];
    logic [31:0] wr_addr [2];
    logic [31:0] wr_data [2];
    logic [31:0] ram_data[2];
    logic        done_rd [2];
    logic        done_wr [2];
    logic        busy    [2];
`ifdef DATA_RAM_PERF_EN
    logic [31:0] rd_count  [2];
    logic [31:0] wr_count  [2];
    logic [31:0] conf_count[2];
`endif

    data_ram_responder #(.ADDR_W(10), .READ_LAT(4), .WRITE_LAT(4)) u0 (
        .clk(clk), .nReset(rst_n[0]),
        .RamRead(rd_req[0]), .RamReadAddress(rd_addr[0]),
        .RamWrite(wr_req[0]), .RamWriteAddress(wr_addr[0]), .RamWriteData(wr_data[0]),
        .RamData(ram_data[0]), .DoneReadingData(done_rd[0]), .DoneWritingData(done_wr[0]),
        .Busy(busy[0])
`ifdef DATA_RAM_PERF_EN
        , .RdCount(rd_count[0]), .WrCount(wr_count[0]), .ConflictCount(conf_count[0])
`endif
    );

    data_ram_responder #(.ADDR_W(10), .READ_LAT(1), .WRITE_LAT(1)) u1 (
        .clk(clk), .nReset(rst_n[1]),
        .RamRead(rd_req[1]), .RamReadAddress(rd_addr[1]),
        .RamWrite(wr_req[1]), .RamWriteAddress(wr_addr[1]), .RamWriteData(wr_data[1]),
        .RamData(ram_data[1]), .DoneReadingData(done_rd[1]), .DoneWritingData(done_wr[1]),
        .Busy(busy[1])
`ifdef DATA_RAM_PERF_EN
        , .RdCount(rd_count[1]), .WrCount(wr_count[1]), .ConflictCount(conf_count[1])
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Transaction-level reference: accepted in cycle A => busy A+1..A+LAT, Done in A+LAT.
    int          lat_r [2] = '{4, 1};
    int          lat_w [2] = '{4, 1};
    int          acc_at [2] = '{-1, -1};
    int          done_at[2] = '{-1, -1};
    bit          op_wr  [2];
    bit          last_wr[2] = '{1'b1, 1'b1};
    logic [31:0] pend   [2];
    bit          pend_known[2];
    logic [31:0] exp_data  [2];
    bit          data_known[2];
    logic [31:0] mmem  [2][1024];
    bit          mvalid[2][1024];
`ifdef DATA_RAM_PERF_EN
    logic [31:0] m_rd[2], m_wr[2], m_conf[2];
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin : model
        int ri, wi;
        bit gr, gw;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                acc_at[i]  = -1;
                done_at[i] = -1;
                last_wr[i] = 1'b1;
`ifdef DATA_RAM_PERF_EN
                m_rd[i] = 0; m_wr[i] = 0; m_conf[i] = 0;
`endif
            end else if (cyc > done_at[i]) begin
                ri = int'(rd_addr[i][11:2]);
                wi = int'(wr_addr[i][11:2]);
                gr = 1'b0;
                gw = 1'b0;
                if (rd_req[i] && wr_req[i]) begin
`ifdef DATA_RAM_PERF_EN
                    m_conf[i] = m_conf[i] + 1;
`endif
                    if (ri == wi) begin
                        gw = 1'b1;
                    end else begin
                        gw = !last_wr[i];
                        gr = last_wr[i];
                        last_wr[i] = gw;
                    end
                end else begin
                    gr = rd_req[i];
                    gw = wr_req[i];
                end
                if (gw) begin
                    mmem[i][wi]   = wr_data[i];
                    mvalid[i][wi] = 1'b1;
                    op_wr[i]      = 1'b1;
                    acc_at[i]     = cyc;
                    done_at[i]    = cyc + lat_w[i];
`ifdef DATA_RAM_PERF_EN
                    m_wr[i] = m_wr[i] + 1;
`endif
                end else if (gr) begin
                    pend[i]       = mmem[i][ri];
                    pend_known[i] = mvalid[i][ri];
                    op_wr[i]      = 1'b0;
                    acc_at[i]     = cyc;
                    done_at[i]    = cyc + lat_r[i];
`ifdef DATA_RAM_PERF_EN
                    m_rd[i] = m_rd[i] + 1;
`endif
                end
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin : compare
        bit eb, edr, edw;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                eb = 1'b0; edr = 1'b0; edw = 1'b0;
                exp_data[i]   = '0;
                data_known[i] = 1'b1;
            end else begin
                eb  = (cyc > acc_at[i]) && (cyc <= done_at[i]);
                edr = (cyc == done_at[i]) && !op_wr[i];
                edw = (cyc == done_at[i]) && op_wr[i];
                if (edr) begin
                    exp_data[i]   = pend[i];
                    data_known[i] = pend_known[i];
                end
            end
            chk($sformatf("busy%0d", i), 64'(busy[i]), 64'(eb));
            chk($sformatf("done_rd%0d", i), 64'(done_rd[i]), 64'(edr));
            chk($sformatf("done_wr%0d", i), 64'(done_wr[i]), 64'(edw));
            if (data_known[i]) chk($sformatf("ram_data%0d", i), 64'(ram_data[i]), 64'(exp_data[i]));
`ifdef DATA_RAM_PERF_EN
            if (!rst_n[i]) begin
                m_rd[i] = 0; m_wr[i] = 0; m_conf[i] = 0;
            end
            chk($sformatf("rd_count%0d", i), 64'(rd_count[i]), 64'(m_rd[i]));
            chk($sformatf("wr_count%0d", i), 64'(wr_count[i]), 64'(m_wr[i]));
            chk($sformatf("conf_count%0d", i), 64'(conf_count[i]), 64'(m_conf[i]));
`endif
        end
    end

    task automatic do_reset(input int i);
        rst_n[i] = 1'b0;
        tick();
        tick();
        rst_n[i] = 1'b1;
    endtask

    task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d, output int lat);
        int a_c;
        a_c = cyc;
        wr_req[i] = 1'b1; wr_addr[i] = a; wr_data[i] = d;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done_wr[i]) begin lat = cyc - a_c; break; end
        end
        tick();
        wr_req[i] = 1'b0;
    endtask

    task automatic do_read(input int i, input logic [31:0] a, output int lat, output logic [31:0] d);
        int a_c;
        a_c = cyc;
        rd_req[i] = 1'b1; rd_addr[i] = a;
        lat = -1;
        d = 'x;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done_rd[i]) begin lat = cyc - a_c; d = ram_data[i]; break; end
        end
        tick();
        rd_req[i] = 1'b0;
    endtask

    // Holds both requests; order collects one bit per Done (1 = write), oldest first in higher bits.
    task automatic run_both(input int i, input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd,
                            input bit keep, input int nev,
                            output logic [7:0] order, output int nseen, output int coinc, output logic [31:0] rdv);
        bit drop_rd, drop_wr;
        drop_rd = 1'b0; drop_wr = 1'b0;
        order = '0; nseen = 0; coinc = 0; rdv = 'x;
        rd_req[i] = 1'b1; rd_addr[i] = ra;
        wr_req[i] = 1'b1; wr_addr[i] = wa; wr_data[i] = wd;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (drop_rd) begin rd_req[i] = 1'b0; drop_rd = 1'b0; end
            if (drop_wr) begin wr_req[i] = 1'b0; drop_wr = 1'b0; end
            if (nseen >= nev) break;
            if (done_rd[i] && done_wr[i]) coinc++;
            if (done_wr[i]) begin
                order = {order[6:0], 1'b1}; nseen++;
                if (!keep) drop_wr = 1'b1;
            end
            if (done_rd[i]) begin
                order = {order[6:0], 1'b0}; nseen++; rdv = ram_data[i];
                if (!keep) drop_rd = 1'b1;
            end
            if (nseen >= nev) begin drop_rd = 1'b1; drop_wr = 1'b1; end
        end
        rd_req[i] = 1'b0;
        wr_req[i] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom & 32'hFFFF_F003;
        r[4:2] = 3'($urandom_range(0, 7));
        return r;
    endfunction

    task automatic rand_drive(input int i, input int n);
        bit rfin, wfin;
        rfin = 1'b0; wfin = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (rfin) begin
                rfin = 1'b0;
                if ($urandom_range(0, 1) == 1) rd_addr[i] = rand_addr();
                else rd_req[i] = 1'b0;
            end else if (!rd_req[i]) begin
                if ($urandom_range(0, 2) == 0) begin rd_req[i] = 1'b1; rd_addr[i] = rand_addr(); end
            end else if (busy[i] && $urandom_range(0, 40) == 0) begin
                rd_req[i] = 1'b0;
            end
            if (wfin) begin
                wfin = 1'b0;
                if ($urandom_range(0, 1) == 1) begin wr_addr[i] = rand_addr(); wr_data[i] = $urandom; end
                else wr_req[i] = 1'b0;
            end else if (!wr_req[i]) begin
                if ($urandom_range(0, 2) == 0) begin
                    wr_req[i] = 1'b1; wr_addr[i] = rand_addr(); wr_data[i] = $urandom;
                end
            end else if (busy[i] && $urandom_range(0, 40) == 0) begin
                wr_req[i] = 1'b0;
            end
            if (done_rd[i]) rfin = 1'b1;
            if (done_wr[i]) wfin = 1'b1;
        end
        rd_req[i] = 1'b0;
        wr_req[i] = 1'b0;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, n, nseen, coinc, prev, cnt;
        logic [31:0] d;
        logic [7:0]  order;
        bit change;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b1; rd_req[i] = 1'b0; wr_req[i] = 1'b0;
            rd_addr[i] = '0; wr_addr[i] = '0; wr_data[i] = '0;
        end
        #1;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        repeat (3) tick();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        n = 0;
        repeat (20) begin
            tick();
            n += int'(done_rd[0]) + int'(done_wr[0]) + int'(done_rd[1]) + int'(done_wr[1]);
        end
        chk("idle_done_count", 64'(n), 64'd0);
        chk("idle_busy", 64'(busy[0]), 64'd0);
        chk("idle_ram_data", 64'(ram_data[0]), 64'd0);

        do_write(0, 32'h0000_0010, 32'hDEAD_BEEF, lat);
        chk("write_latency", 64'(lat), 64'd4);
        do_read(0, 32'h0000_0010, lat, d);
        chk("read_latency", 64'(lat), 64'd4);
        chk("read_data_deadbeef", 64'(d), 64'h0000_0000_DEAD_BEEF);

        run_both(0, 32'h20, 32'h20, 32'h1234_5678, 1'b0, 2, order, nseen, coinc, d);
        chk("same_addr_events", 64'(nseen), 64'd2);
        chk("same_addr_order", 64'(order), 64'h02);
        chk("same_addr_data", 64'(d), 64'h0000_0000_1234_5678);

        do_reset(0);
        run_both(0, 32'h40, 32'h44, 32'h5555_AAAA, 1'b1, 4, order, nseen, coinc, d);
        chk("contend_events", 64'(nseen), 64'd4);
        chk("contend_order", 64'(order), 64'h05);
        chk("contend_coincident", 64'(coinc), 64'd0);
        repeat (3) tick();

        wr_req[0] = 1'b1; wr_addr[0] = 32'h80; wr_data[0] = 32'hA5A5_5A5A;
        tick();
        tick();
        rst_n[0] = 1'b0;
        wr_req[0] = 1'b0;
        tick();
        rst_n[0] = 1'b1;
        n = 0;
        repeat (10) begin tick(); n += int'(done_wr[0]); end
        chk("reset_no_done", 64'(n), 64'd0);
        do_read(0, 32'h80, lat, d);
        chk("reset_read_latency", 64'(lat), 64'd4);
        chk("reset_write_kept", 64'(d), 64'h0000_0000_A5A5_5A5A);

        do_write(1, 32'h0000_1000, 32'hCAFE_F00D, lat);
        chk("lat1_write_latency", 64'(lat), 64'd1);
        do_read(1, 32'h0000_0000, lat, d);
        chk("lat1_read_latency", 64'(lat), 64'd1);
        chk("lat1_wrap_data", 64'(d), 64'h0000_0000_CAFE_F00D);

        rd_req[1] = 1'b1; rd_addr[1] = 32'h0;
        prev = -1; cnt = 0; change = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (change) begin rd_addr[1] = rd_addr[1] + 32'd4; change = 1'b0; end
            if (cnt >= 5) break;
            if (done_rd[1]) begin
                if (prev >= 0) chk("lat1_stream_gap", 64'(cyc - prev), 64'd2);
                prev = cyc; cnt++; change = 1'b1;
            end
        end
        rd_req[1] = 1'b0;
        chk("lat1_stream_count", 64'(cnt), 64'd5);
        repeat (3) tick();

        fork
            rand_drive(0, 2500);
            rand_drive(1, 2500);
        join
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
